// File: rtl/pass_cmp_pkg.sv
// ----------------------------------------------------------------------------
// pass_cmp_pkg: shared types for the pass-through stream comparator.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pass_cmp_pkg;

  localparam int STATE_W        = 2;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  // Sample layout for the default data width; the top builds the same
  // {bool,data} concatenation at its configured width.
  typedef struct packed {
    logic                      bool_bit;
    logic [DEF_DATA_WIDTH-1:0] data;
  } sample_t;

endpackage

`default_nettype wire

// File: rtl/pass_cmp_fifo.sv
// ----------------------------------------------------------------------------
// pass_cmp_fifo: synchronous FIFO holding one side's {bool,data} samples.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pass_cmp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pass_compare.sv
// ----------------------------------------------------------------------------
// pass_compare: compares reference and RTL sample streams with skew FIFOs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pass_compare
  import pass_cmp_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  a_valid_i,
  input  logic                  a_bool_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  input  logic                  b_bool_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  cmp_valid_o,
  output logic                  match_o,
  output logic [CNT_WIDTH-1:0]  match_cnt_o,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt_o,
  output logic [CNT_WIDTH-1:0]  first_idx_o,
  output logic [DATA_WIDTH:0]   first_a_o,
  output logic [DATA_WIDTH:0]   first_b_o,
  output logic                  overflow_o,
  output logic                  timeout_o,
  output logic [1:0]            state_o
);

  localparam int                   TW      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                push_a;
  logic                push_b;
  logic                full_a;
  logic                full_b;
  logic                empty_a;
  logic                empty_b;
  logic                pop;
  logic                one_side;
  logic                ovf;
  logic                to_hit;
  logic                mm_evt;
  logic                stop_pend;
  logic [DATA_WIDTH:0] a_in;
  logic [DATA_WIDTH:0] b_in;
  logic [DATA_WIDTH:0] head_a;
  logic [DATA_WIDTH:0] head_b;

  // Pop stage: heads captured at the pop edge, compared the edge after.
  logic                p_valid;
  logic [DATA_WIDTH:0] p_a;
  logic [DATA_WIDTH:0] p_b;
  logic [CNT_WIDTH-1:0] p_idx;
  logic                p_match;
  logic [CNT_WIDTH-1:0] idx;
  logic [TW-1:0]       tcnt;

  assign a_in      = {a_bool_i, a_data_i};
  assign b_in      = {b_bool_i, b_data_i};
  assign accept    = (state != FAIL);
  assign push_a    = a_valid_i && accept;
  assign push_b    = b_valid_i && accept;
  assign p_match   = (p_a == p_b);
  assign mm_evt    = p_valid && !p_match;
  // Holding off the next pop keeps nothing in flight once a stopping mismatch lands.
  assign stop_pend = (STOP_ON_FAIL != 0) && mm_evt;
  assign pop       = (state == RUN) && !empty_a && !empty_b && !stop_pend;
  assign one_side  = (state == RUN) && (empty_a != empty_b);
  assign ovf       = (push_a && full_a && !pop) || (push_b && full_b && !pop);
  assign to_hit    = one_side && (tcnt == TO_LAST);

  pass_cmp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear_i),
    .push  (push_a),
    .pop   (pop),
    .din   (a_in),
    .full  (full_a),
    .empty (empty_a),
    .head  (head_a)
  );

  pass_cmp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear_i),
    .push  (push_b),
    .pop   (pop),
    .din   (b_in),
    .full  (full_b),
    .empty (empty_b),
    .head  (head_b)
  );

  always_ff @(posedge clk) begin
    if (!rstn || clear_i) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push_a || push_b) state_nxt = RUN;
      RUN:  if (ovf || to_hit || ((STOP_ON_FAIL != 0) && mm_evt)) state_nxt = FAIL;
      FAIL: state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    state_o = state;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      p_valid        <= 1'b0;
      p_a            <= '0;
      p_b            <= '0;
      p_idx          <= '0;
      idx            <= '0;
      cmp_valid_o    <= 1'b0;
      match_o        <= 1'b0;
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      first_idx_o    <= '0;
      first_a_o      <= '0;
      first_b_o      <= '0;
      overflow_o     <= 1'b0;
      timeout_o      <= 1'b0;
      tcnt           <= '0;
    end else begin
      p_valid <= pop;
      if (pop) begin
        p_a   <= head_a;
        p_b   <= head_b;
        p_idx <= idx;
        if (idx != CNT_MAX) idx <= idx + 1'b1;
      end

      cmp_valid_o <= p_valid;
      match_o     <= p_valid && p_match;
      if (p_valid && p_match && (match_cnt_o != CNT_MAX))
        match_cnt_o <= match_cnt_o + 1'b1;
      if (mm_evt) begin
        if (mismatch_cnt_o == '0) begin
          first_idx_o <= p_idx;
          first_a_o   <= p_a;
          first_b_o   <= p_b;
        end
        if (mismatch_cnt_o != CNT_MAX) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
      end

      if (ovf)    overflow_o <= 1'b1;
      if (to_hit) timeout_o  <= 1'b1;

      if (pop || (empty_a && empty_b)) tcnt <= '0;
      else if (one_side)               tcnt <= tcnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pass_compare.sv
// ----------------------------------------------------------------------------
// tb_pass_compare: directed checks of two comparator configurations.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pass_compare;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clear_i;
  logic       a_valid_i, a_bool_i, b_valid_i, b_bool_i;
  logic [7:0] a_data_i, b_data_i;

  // s_*: DEPTH=4, STOP_ON_FAIL=1, 16-bit counters
  logic        s_cv, s_m, s_ovf, s_tmo;
  logic [15:0] s_mc, s_mm, s_fi;
  logic [8:0]  s_fa, s_fb;
  logic [1:0]  s_st;
  // c_*: DEPTH=8, STOP_ON_FAIL=0, 3-bit counters (saturate at 7)
  logic        c_cv, c_m, c_ovf, c_tmo;
  logic [2:0]  c_mc, c_mm, c_fi;
  logic [8:0]  c_fa, c_fb;
  logic [1:0]  c_st;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pass_compare #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(16), .TIMEOUT(64), .STOP_ON_FAIL(1)) u_dut_s (
    .clk(clk), .rstn(rstn), .clear_i(clear_i),
    .a_valid_i(a_valid_i), .a_bool_i(a_bool_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_bool_i(b_bool_i), .b_data_i(b_data_i),
    .cmp_valid_o(s_cv), .match_o(s_m), .match_cnt_o(s_mc), .mismatch_cnt_o(s_mm),
    .first_idx_o(s_fi), .first_a_o(s_fa), .first_b_o(s_fb),
    .overflow_o(s_ovf), .timeout_o(s_tmo), .state_o(s_st)
  );

  pass_compare #(.DATA_WIDTH(8), .DEPTH(8), .CNT_WIDTH(3), .TIMEOUT(64), .STOP_ON_FAIL(0)) u_dut_c (
    .clk(clk), .rstn(rstn), .clear_i(clear_i),
    .a_valid_i(a_valid_i), .a_bool_i(a_bool_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_bool_i(b_bool_i), .b_data_i(b_data_i),
    .cmp_valid_o(c_cv), .match_o(c_m), .match_cnt_o(c_mc), .mismatch_cnt_o(c_mm),
    .first_idx_o(c_fi), .first_a_o(c_fa), .first_b_o(c_fb),
    .overflow_o(c_ovf), .timeout_o(c_tmo), .state_o(c_st)
  );

  typedef struct {
    logic       av, ab, bv, bb;
    logic [7:0] ad, bd;
    logic       ecv, em;
    logic [15:0] emc, emm;
    logic [1:0] est;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic ab, input logic [7:0] ad,
                       input logic bv, input logic bb, input logic [7:0] bd);
    a_valid_i = av; a_bool_i = ab; a_data_i = ad;
    b_valid_i = bv; b_bool_i = bb; b_data_i = bd;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
  endtask

  vec_t       tbl [11];
  logic [7:0] rnd [10];
  logic       ecv_l [11] = '{0,0,1,1,1,1,1,0,0,0,0};
  logic       em_l  [11] = '{0,0,1,1,1,1,0,0,0,0,0};
  int         emc_l [11] = '{0,0,1,2,3,4,4,4,4,4,4};
  int         emm_l [11] = '{0,0,0,0,0,0,1,1,1,1,1};
  int         est_l [11] = '{1,1,1,1,1,1,2,2,2,2,2};

  initial begin
    // Data-mismatch stream: sample 4 differs in data only; rows 8..10 idle.
    for (int i = 0; i < 11; i++) begin
      tbl[i].av  = (i < 8);
      tbl[i].bv  = (i < 8);
      tbl[i].ab  = (i % 2 == 1);
      tbl[i].bb  = (i % 2 == 1);
      tbl[i].ad  = 8'(8'h10 + i);
      tbl[i].bd  = 8'(8'h10 + i);
      tbl[i].ecv = ecv_l[i];
      tbl[i].em  = em_l[i];
      tbl[i].emc = 16'(emc_l[i]);
      tbl[i].emm = 16'(emm_l[i]);
      tbl[i].est = 2'(est_l[i]);
    end
    tbl[4].ad = 8'h5A;
    tbl[4].bd = 8'h5B;

    clear_i = 1'b0;
    rstn    = 1'b0;
    idle(2);
    chk("reset_state", 32'(s_st), 32'd0);
    chk("reset_mc", 32'(s_mc), 32'd0);
    chk("reset_cv", 32'(s_cv), 32'd0);
    chk("reset_flags", {30'd0, s_ovf, s_tmo}, 32'd0);
    rstn = 1'b1;

    // Identical streams, same cycle, with first-result latency
    for (int i = 0; i < 10; i++) rnd[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      drive(1, rnd[i][0], rnd[i], 1, rnd[i][0], rnd[i]);
      tick();
      if (i == 1) chk("lat_cv_edge1", 32'(s_cv), 32'd0);
      if (i == 2) begin
        chk("lat_cv_edge2", 32'(s_cv), 32'd1);
        chk("lat_match_edge2", 32'(s_m), 32'd1);
        chk("lat_mc_edge2", 32'(s_mc), 32'd1);
      end
    end
    idle(4);
    chk("ident_mc", 32'(s_mc), 32'd10);
    chk("ident_mm", 32'(s_mm), 32'd0);
    chk("ident_state", 32'(s_st), 32'd1);
    chk("ident_flags", {30'd0, s_ovf, s_tmo}, 32'd0);
    chk("ident_c_mc_sat", 32'(c_mc), 32'd7);

    // Table-driven data mismatch, cycle by cycle on the stopping instance
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].av, tbl[i].ab, tbl[i].ad, tbl[i].bv, tbl[i].bb, tbl[i].bd);
      tick();
      chk($sformatf("tbl%0d_cv", i), 32'(s_cv), 32'(tbl[i].ecv));
      chk($sformatf("tbl%0d_match", i), 32'(s_m), 32'(tbl[i].em));
      chk($sformatf("tbl%0d_mc", i), 32'(s_mc), 32'(tbl[i].emc));
      chk($sformatf("tbl%0d_mm", i), 32'(s_mm), 32'(tbl[i].emm));
      chk($sformatf("tbl%0d_state", i), 32'(s_st), 32'(tbl[i].est));
    end
    chk("dmm_first_idx", 32'(s_fi), 32'd4);
    chk("dmm_first_a", 32'(s_fa[7:0]), 32'h5A);
    chk("dmm_first_b", 32'(s_fb[7:0]), 32'h5B);
    chk("dmm_c_mc", 32'(c_mc), 32'd7);
    chk("dmm_c_mm", 32'(c_mm), 32'd1);
    chk("dmm_c_state", 32'(c_st), 32'd1);

    // Bool-only mismatch at sample 2
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b0, 8'(8'h20 + i), 1, (i == 2), 8'(8'h20 + i));
      tick();
    end
    idle(4);
    chk("bmm_c_mm", 32'(c_mm), 32'd1);
    chk("bmm_c_mc", 32'(c_mc), 32'd7);
    chk("bmm_c_idx", 32'(c_fi), 32'd2);
    chk("bmm_c_fa", 32'(c_fa), 32'h022);
    chk("bmm_c_fb", 32'(c_fb), 32'h122);
    chk("bmm_c_state", 32'(c_st), 32'd1);
    chk("bmm_s_mc", 32'(s_mc), 32'd2);
    chk("bmm_s_state", 32'(s_st), 32'd2);

    // Skew: B lags A by 3 cycles, 20 samples; A FIFO (depth 4) runs full
    do_reset();
    for (int t = 0; t < 23; t++) begin
      drive(t < 20, 1'(t >> 1), 8'(t * 7 + 3),
            t >= 3, 1'((t - 3) >> 1), 8'((t - 3) * 7 + 3));
      tick();
    end
    idle(4);
    chk("skew_mc", 32'(s_mc), 32'd20);
    chk("skew_mm", 32'(s_mm), 32'd0);
    chk("skew_ovf", 32'(s_ovf), 32'd0);
    chk("skew_state", 32'(s_st), 32'd1);

    // Reset mid-stream with samples in flight
    drive(1, 0, 8'h11, 0, 0, 8'h00); tick();
    drive(1, 0, 8'h22, 0, 0, 8'h00); tick();
    drive(1, 0, 8'h33, 1, 0, 8'h11); tick();
    do_reset();
    chk("mrst_mc", 32'(s_mc), 32'd0);
    chk("mrst_flags", {30'd0, s_ovf, s_tmo}, 32'd0);
    chk("mrst_state", 32'(s_st), 32'd0);
    drive(1, 0, 8'h77, 1, 0, 8'h77); tick();
    idle(4);
    chk("mrst_pair_mc", 32'(s_mc), 32'd1);
    chk("mrst_pair_mm", 32'(s_mm), 32'd0);

    // Overflow: 5 pushes on A only into the depth-4 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'(i), 0, 0, 8'h00);
      tick();
      if (i == 3) begin
        chk("ovf_before", 32'(s_ovf), 32'd0);
        chk("ovf_before_state", 32'(s_st), 32'd1);
      end
    end
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_state", 32'(s_st), 32'd2);
    chk("ovf_c_depth8", 32'(c_ovf), 32'd0);
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    chk("clear_ovf", 32'(s_ovf), 32'd0);
    chk("clear_state", 32'(s_st), 32'd0);

    // Timeout: a single A sample with B silent
    do_reset();
    drive(1, 1, 8'hC3, 0, 0, 8'h00);
    tick();
    idle(63);
    chk("tmo_edge63", 32'(s_tmo), 32'd0);
    idle(1);
    chk("tmo_edge64", 32'(s_tmo), 32'd1);
    chk("tmo_state", 32'(s_st), 32'd2);
    chk("tmo_c", 32'(c_tmo), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
